// File: rtl/ahb_key_led_pkg.sv
// Shared AHB-Lite constants and sequencer state type for the key-driven LED sequencer.
package ahb_key_led_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchroniser, stability counter and registered press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive synced samples that disagree with the accepted level.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_ni;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ahb_key_led_seq.sv
// Key-driven AHB-Lite master: debounced presses toggle LED register bits by read-modify-write.
// Optional macro AHB_KEY_LED_SEQ_RETRY_EN re-issues a failed phase once before flagging bus_err.
module ahb_key_led_seq
  import ahb_key_led_pkg::*;
#(
  parameter int          KEY_W           = 4,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] LED_ADDR        = 32'h4000_0000
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [KEY_W-1:0] key_n,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  output logic             busy,
  output logic             bus_err
);

  logic [KEY_W-1:0] press_s, clr_s;
  logic [KEY_W-1:0] pending_q, pending_d, mask_q, mask_d;
  state_e           state_q, state_d;
  logic [31:0]      rd_q, rd_d, haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic [1:0]       htrans_q, htrans_d;
  logic             hwrite_q, hwrite_d, busy_q, busy_d, bus_err_q, bus_err_d;
  logic             err_s;
`ifdef AHB_KEY_LED_SEQ_RETRY_EN
  logic             retry_q, retry_d;
`endif

  for (genvar g = 0; g < KEY_W; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk_i  (HCLK),
      .rst_ni (HRESETn),
      .key_ni (key_n[g]),
      .press_o(press_s[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    rd_d      = rd_q;
    bus_err_d = bus_err_q;
    clr_s     = '0;
    err_s     = 1'b0;
`ifdef AHB_KEY_LED_SEQ_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((pending_q != '0) && HREADY) begin
          mask_d  = pending_q;
          clr_s   = pending_q;
          state_d = ST_RD_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_A: state_d = HREADY ? ST_RD_D : ST_RD_A;
      ST_RD_D: begin
        if (HREADY && HRESP) begin
          err_s = 1'b1;
        end else if (HREADY) begin
          rd_d    = HRDATA;
          state_d = ST_WR_A;
        end else begin
          state_d = ST_RD_D;
        end
      end
      ST_WR_A: state_d = HREADY ? ST_WR_D : ST_WR_A;
      ST_WR_D: begin
        if (HREADY && HRESP) begin
          err_s = 1'b1;
        end else if (HREADY) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_D;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Second ERROR cycle: either re-issue the failed address phase or abort the batch.
    if (err_s) begin
`ifdef AHB_KEY_LED_SEQ_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        state_d = (state_q == ST_WR_D) ? ST_WR_A : ST_RD_A;
      end else begin
        bus_err_d = 1'b1;
        mask_d    = '0;
        state_d   = ST_IDLE;
      end
`else
      bus_err_d = 1'b1;
      mask_d    = '0;
      state_d   = ST_IDLE;
`endif
    end else begin
      bus_err_d = bus_err_d;
    end
`ifdef AHB_KEY_LED_SEQ_RETRY_EN
    retry_d = (state_d == ST_IDLE) ? 1'b0 : retry_d;
`endif

    // A press arriving in the same cycle as the snapshot survives the clear.
    pending_d = (pending_q & ~clr_s) | press_s;
    htrans_d  = ((state_d == ST_RD_A) || (state_d == ST_WR_A)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr_d   = (htrans_d == HTRANS_NONSEQ) ? LED_ADDR : haddr_q;
    hwrite_d  = (state_d == ST_WR_A) ? 1'b1 : ((state_d == ST_RD_A) ? 1'b0 : hwrite_q);
    hwdata_d  = ((state_q == ST_WR_A) && HREADY) ? (rd_q ^ 32'(mask_q)) : hwdata_q;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      rd_q      <= 32'h0000_0000;
      haddr_q   <= 32'h0000_0000;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hwdata_q  <= 32'h0000_0000;
      busy_q    <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef AHB_KEY_LED_SEQ_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      rd_q      <= rd_d;
      haddr_q   <= haddr_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
      busy_q    <= busy_d;
      bus_err_q <= bus_err_d;
`ifdef AHB_KEY_LED_SEQ_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign HADDR   = haddr_q;
  assign HTRANS  = htrans_q;
  assign HWRITE  = hwrite_q;
  assign HSIZE   = HSIZE_WORD;
  assign HBURST  = HBURST_SINGLE;
  assign HWDATA  = hwdata_q;
  assign busy    = busy_q;
  assign bus_err = bus_err_q;

endmodule

// File: doc/ahb_key_led_seq.md
Name: ahb_key_led_seq

Overview:
- AHB-Lite single-master sequencer between the board push-buttons and the LED peripheral register.
- Synchronises and debounces active-low keys, then collects press events into a pending mask.
- For each batch it runs a read-modify-write on the LED register: LED_new = LED_old XOR mask.
- Sits in SoC_top as the key-driven bus master feeding the AHB interconnect.

Parameters:
- KEY_W, 4, number of keys / LED bits toggled.
- DEBOUNCE_CYCLES, 4, consecutive stable HCLK cycles required to accept a key level (>=1).
- LED_ADDR, 32'h4000_0000, byte address of the LED data register.

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  asynchronous active-low reset.
- key_n  in  KEY_W  raw keys, 0 = pressed, asynchronous to HCLK.
- HADDR  out  32  AHB address.
- HTRANS  out  2  IDLE=2'b00 or NONSEQ=2'b10 only.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  fixed 3'b010 (word).
- HBURST  out  3  fixed 3'b000 (SINGLE).
- HWDATA  out  32  write data, valid in the write data phase.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer done / bus ready.
- HRESP  in  1  0 = OKAY, 1 = ERROR.
- busy  out  1  FSM not in IDLE.
- bus_err  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset values: HADDR=0, HTRANS=IDLE, HWRITE=0, HWDATA=0, busy=0, bus_err=0. Also cleared: debounce counters, pending mask, internal state.
- Per-key front end:
  - 2-FF synchroniser; synced reset value is 1 (released).
  - Per-key debounce counter of width clog2(DEBOUNCE_CYCLES+1). The stable level updates after DEBOUNCE_CYCLES consecutive equal synced samples that differ from the current stable level.
  - Press event = stable level 1->0.
  - Latency from raw edge to pending bit set: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- pending[KEY_W-1:0] accumulates press events (OR). A bit set and cleared in the same cycle stays set, so a new event is not lost.
- FSM states: IDLE, RD_A, RD_D, WR_A, WR_D.
  - IDLE: when pending!=0 and HREADY=1, snapshot mask<=pending, clear those pending bits, go to RD_A.
  - RD_A: drive HTRANS=NONSEQ, HWRITE=0, HADDR=LED_ADDR. Advance to RD_D on HREADY=1; otherwise hold the address phase.
  - RD_D: HTRANS=IDLE. On HREADY=1 with HRESP=0, capture rd<=HRDATA, go to WR_A.
  - WR_A: HTRANS=NONSEQ, HWRITE=1, HADDR=LED_ADDR. Advance on HREADY=1.
  - WR_D: HWDATA = rd ^ {zero-extend mask}, held stable until HREADY=1. With HRESP=0 go to IDLE.
- ERROR response in RD_D or WR_D:
  - On the first cycle of HRESP=1 (HREADY=0), HTRANS is already IDLE and stays IDLE.
  - On the second cycle (HREADY=1): set bus_err=1, discard mask, go to IDLE.
  - See the optional feature for the retry variant.
- Keys pressed during a sequence: accumulate in pending and are served by the next sequence. No event is dropped.
- A key pressed twice before service collapses to one toggle (OR semantics).
- Reset mid-sequence: immediately HTRANS=IDLE, state=IDLE, pending cleared.
- Only bits [KEY_W-1:0] of the LED register change; upper bits are written back unchanged.

Optional Feature:
- Macro: AHB_KEY_LED_SEQ_RETRY_EN.
- Defined:
  - After an ERROR, the failed phase is re-issued once (RD_D -> RD_A, WR_D -> WR_A), tracked by a 1-bit retry flag that is cleared on entry to IDLE.
  - bus_err is set and the mask discarded only if the retry also errors.
- Undefined: the first ERROR sets bus_err and aborts, as above.

Decomposition:
- Package ahb_key_led_pkg holds:
  - HTRANS_IDLE / HTRANS_NONSEQ constants.
  - HSIZE_WORD and HBURST_SINGLE constants.
  - FSM state enum type.
- One natural sub-module: key_debounce. It contains the synchroniser, counter and stable-level/press-event logic for one key, with DEBOUNCE_CYCLES as its parameter. It is instantiated KEY_W times with a generate loop.

Test Plan:
- Reset:
  - Stimulus: HRESETn=0 with key_n=4'b0000.
  - Required: HTRANS=00, busy=0, bus_err=0. After release with keys held at 1111, no bus activity for 100 cycles.
- Single press:
  - Stimulus: slave returns HRDATA=32'h0000_0000; key_n=1110 for 5 cycles.
  - Required: exactly one read then one write to 32'h4000_0000, with HWDATA=32'h0000_0001.
- All keys:
  - Stimulus: LED register =32'hFFFF_FFF5; key_n=0000 for 5 cycles.
  - Required: HWDATA=32'hFFFF_FFFA.
- Glitch and overlap:
  - A 2-cycle low glitch on key1 produces no transfer.
  - A key2 press during a 3-wait-state read produces a second RMW with mask 4'b0100 after the first completes.
- Error:
  - Stimulus: two-cycle ERROR on the write.
  - Required without the macro: bus_err=1 and FSM back in IDLE.
  - Required with AHB_KEY_LED_SEQ_RETRY_EN: the write is reissued, and an OKAY retry leaves bus_err=0.
- Reset mid-sequence:
  - Stimulus: assert HRESETn=0 in RD_D.
  - Required: HTRANS=00 the same cycle, pending=0; after reset, no transfer until a new press.
